// File: rtl/ym_i2s_tx.sv
// Philips I2S transmitter for the PSG: captures unsigned 10-bit L/R once per
// 32-slot frame, converts to signed 16-bit and shifts out MSB first.
module ym_i2s_tx #(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] AUDIO_L,
  input  logic [9:0] AUDIO_R,
  input  logic       MUTE,
  output logic       I2S_SCLK,
  output logic       I2S_LRCK,
  output logic       I2S_SDATA,
  output logic       FRAME_STB
);

  localparam int unsigned      DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       slot;
  logic [31:0]      shreg;

  logic             div_wrap;
  logic             fe;
  logic [4:0]       slot_nxt;
  logic [31:0]      shreg_nxt;

  // Offset-binary to two's complement, left-justified in 16 bits.
  function automatic logic [15:0] conv(input logic [9:0] x);
    return {~x[9], x[8:0], 6'b0};
  endfunction

  always_comb begin
    div_wrap = (div_cnt == DIV_MAX);
    fe       = div_wrap && I2S_SCLK;
    slot_nxt = slot + 5'd1;
    if (slot_nxt == 5'd0)
      shreg_nxt = MUTE ? '0 : {conv(AUDIO_L), conv(AUDIO_R)};
    else
      shreg_nxt = {shreg[30:0], 1'b0};
  end

  // Every output moves only on an SCLK falling edge, so the DAC sees them
  // stable around the rising edge it samples on.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt   <= '0;
      I2S_SCLK  <= 1'b0;
      I2S_LRCK  <= 1'b0;
      I2S_SDATA <= 1'b0;
      FRAME_STB <= 1'b0;
      slot      <= 5'd31;
      shreg     <= '0;
    end else begin
      FRAME_STB <= 1'b0;
      if (div_wrap) begin
        div_cnt  <= '0;
        I2S_SCLK <= ~I2S_SCLK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fe) begin
        slot      <= slot_nxt;
        shreg     <= shreg_nxt;
        I2S_SDATA <= shreg_nxt[31];
        I2S_LRCK  <= (slot_nxt >= 5'd15) && (slot_nxt != 5'd31);
        FRAME_STB <= (slot_nxt == 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_ym_i2s_tx.sv
// Bench for ym_i2s_tx: two instances (SCLK_DIV=2 and 1), each with a
// deserialising scoreboard, plus table vectors and multi-cycle sequences.
module tb_ym_i2s_tx;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] al [2];
  logic [9:0] ar [2];
  logic       mute [2];
  logic       sclk [2];
  logic       lrck [2];
  logic       sdata [2];
  logic       stb [2];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ym_i2s_tx #(.SCLK_DIV(2)) dut0 (
    .CLK(CLK), .RESET(RESET), .AUDIO_L(al[0]), .AUDIO_R(ar[0]), .MUTE(mute[0]),
    .I2S_SCLK(sclk[0]), .I2S_LRCK(lrck[0]), .I2S_SDATA(sdata[0]), .FRAME_STB(stb[0])
  );

  ym_i2s_tx #(.SCLK_DIV(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .AUDIO_L(al[1]), .AUDIO_R(ar[1]), .MUTE(mute[1]),
    .I2S_SCLK(sclk[1]), .I2S_LRCK(lrck[1]), .I2S_SDATA(sdata[1]), .FRAME_STB(stb[1])
  );

  function automatic logic [15:0] conv(input logic [9:0] x);
    return {~x[9], x[8:0], 6'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int D = (g == 0) ? 2 : 1;
    logic [9:0]  pl, pr;
    logic        pm, rq;
    logic [31:0] exp_q [$];
    logic [31:0] sh = '0;
    logic [31:0] last_word = '0;
    int          idx = 0, words = 0, cyc = 0, last_stb = 0, since_rel = 0;
    logic        active = 1'b0, prev_sclk = 1'b0, first = 1'b1;

    // Inputs as the DUT saw them at this posedge (driver changes them at +2).
    always @(posedge CLK) begin
      pl <= al[g];
      pr <= ar[g];
      pm <= mute[g];
      rq <= RESET;
    end

    always @(negedge CLK) begin
      cyc++;
      if (rq) begin
        check($sformatf("reset_outputs%0d", g),
              {28'b0, sclk[g], lrck[g], sdata[g], stb[g]}, 32'h0);
        active    = 1'b0;
        exp_q.delete();
        since_rel = 0;
        first     = 1'b1;
        prev_sclk = 1'b0;
      end else begin
        since_rel++;
        if (stb[g]) begin
          if (first) check($sformatf("first_fe%0d", g), since_rel, 2 * D);
          else       check($sformatf("frame_period%0d", g), cyc - last_stb, 64 * D);
          first    = 1'b0;
          last_stb = cyc;
          exp_q.push_back(pm ? 32'h0 : {conv(pl), conv(pr)});
          active = 1'b1;
          idx    = 0;
        end
        if (sclk[g] && !prev_sclk && active) begin
          sh = {sh[30:0], sdata[g]};
          check($sformatf("lrck%0d_slot%0d", g, idx), {31'b0, lrck[g]},
                {31'b0, (idx >= 15 && idx <= 30)});
          if (idx == 31) begin
            if (exp_q.size() == 0) check($sformatf("sb_underflow%0d", g), 1, 0);
            else                   check($sformatf("word%0d", g), sh, exp_q.pop_front());
            last_word = sh;
            words++;
            active = 1'b0;
          end
          idx++;
        end
        prev_sclk = sclk[g];
      end
    end
  end

  function automatic int words_of(input int g);
    return (g == 0) ? mon[0].words : mon[1].words;
  endfunction

  task automatic wait_words(input int g, input int n);
    int target;
    bit done;
    target = words_of(g) + n;
    done   = 0;
    for (int c = 0; c < (n + 1) * 64 * 2 * 2 + 50 && !done; c++) begin
      @(posedge CLK);
      if (words_of(g) >= target) done = 1;
    end
    if (!done) check($sformatf("timeout_words%0d", g), 0, 1);
    #2;
  endtask

  task automatic wait_slot0(input int s);
    bit done;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge CLK);
      if (mon[0].active && mon[0].idx == s) done = 1;
    end
    if (!done) check("timeout_slot", 0, 1);
    #2;
  endtask

  typedef struct {
    logic [9:0]  l;
    logic [9:0]  r;
    logic        m;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t vecs [6];
  int   base;

  initial begin
    vecs[0] = '{10'd1023, 10'd0,    1'b0, 16'h7FC0, 16'h8000};
    vecs[1] = '{10'd512,  10'd512,  1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{10'd0,    10'd1023, 1'b0, 16'h8000, 16'h7FC0};
    vecs[3] = '{10'h2AA,  10'h155,  1'b0, 16'h2A80, 16'hD540};
    vecs[4] = '{10'd1,    10'd511,  1'b0, 16'h8040, 16'hFFC0};
    vecs[5] = '{10'd1023, 10'd1023, 1'b1, 16'h0000, 16'h0000};

    for (int g = 0; g < 2; g++) begin
      al[g] = '0; ar[g] = '0; mute[g] = 1'b0;
    end
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;

    for (int i = 0; i < 6; i++) begin
      al[0] = vecs[i].l; ar[0] = vecs[i].r; mute[0] = vecs[i].m;
      wait_words(0, 2);
      check($sformatf("vec%0d", i), mon[0].last_word, {vecs[i].el, vecs[i].er});
    end

    // Mid-frame MUTE/AUDIO changes only take effect at the next capture.
    al[0] = 10'd1023; ar[0] = 10'd0; mute[0] = 1'b0;
    wait_words(0, 2);
    wait_slot0(10);
    mute[0] = 1'b1; al[0] = 10'd0; ar[0] = 10'd1023;
    wait_words(0, 1);
    check("mute_midframe_cur", mon[0].last_word, 32'h7FC0_8000);
    wait_words(0, 1);
    check("mute_next", mon[0].last_word, 32'h0);
    wait_slot0(5);
    mute[0] = 1'b0;
    wait_words(0, 1);
    check("unmute_midframe_cur", mon[0].last_word, 32'h0);
    wait_words(0, 1);
    check("unmute_next", mon[0].last_word, 32'h8000_7FC0);

    // Reset in slot 20: partial frame abandoned, restart with a fresh capture.
    al[0] = 10'd1023; ar[0] = 10'd1023;
    wait_words(0, 2);
    wait_slot0(20);
    base = mon[0].words;
    RESET = 1'b1;
    @(posedge CLK);
    #2 RESET = 1'b0;
    check("reset_drops_word", mon[0].words, base);
    wait_words(0, 1);
    check("after_reset_word", mon[0].last_word, 32'h7FC0_7FC0);

    // SCLK_DIV=1 instance: conv(10'h2AA) = 16'h2A80.
    al[1] = 10'h2AA; ar[1] = 10'h155;
    wait_words(1, 2);
    check("div1_word", mon[1].last_word, 32'h2A80_D540);

    // Random audio changed every CLK; scoreboards check each captured pair.
    base = mon[1].words;
    for (int c = 0; c < 1000 * 64 + 200 && mon[1].words < base + 1000; c++) begin
      for (int g = 0; g < 2; g++) begin
        al[g]   = 10'($urandom);
        ar[g]   = 10'($urandom);
        mute[g] = ($urandom_range(0, 31) == 0);
      end
      @(posedge CLK);
      #2;
    end
    check("random_frames", (mon[1].words >= base + 1000) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
